// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: FSM state codes, legal
// oversampling ratios and the mid-bit strobe offset used by both the
// controller and the data sampler.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Edge index at which every check/shift strobe fires. The sampler's
  // three-point majority ends at P/2+1, so P/2+2 sees a settled bit.
  function automatic logic [7:0] strobe_edge(input logic [7:0] p);
    return (p >> 1) + 8'd2;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the receive controller and its datapath neighbours:
// serial line and frame config in, checker results in, strobes and
// counters out.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      dat_samp_en;
  logic                      deser_en;
  logic                      strt_chk_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      data_valid;
  logic                      frame_err;
  logic                      busy;

  // Controller side.
  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, busy
  );

  // Line / checker side.
  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (0..P-1 per bit) and data-bit counter.
// Bit counter only advances while enabled and sits at 0 otherwise.
module uart_rx_edge_bit_cnt #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic                      i_bit_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic [PRESCALE_WIDTH-1:0] o_edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  o_bit_cnt,
  output logic                      o_end_of_bit
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
  logic                      w_last_edge;
  logic                      w_last_bit;

  assign w_last_edge  = (r_edge_cnt == i_prescale - PRESCALE_WIDTH'(1));
  assign w_last_bit   = (r_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
  assign o_end_of_bit = i_en && w_last_edge;
  assign o_edge_cnt   = r_edge_cnt;
  assign o_bit_cnt    = r_bit_cnt;

  // Edge counter: wraps at the end of each bit, parked at 0 when cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_edge_cnt <= '0;
    else if (i_clr) r_edge_cnt <= '0;
    else if (i_en)  r_edge_cnt <= w_last_edge ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
  end

  // Bit counter: steps once per bit, wraps to 0 after the last data bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     r_bit_cnt <= '0;
    else if (i_clr || !i_bit_en) r_bit_cnt <= '0;
    else if (o_end_of_bit)       r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_CNT_WIDTH'(1);
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, per-bit strobes to the sampler,
// deserializer and checkers, and end-of-frame data_valid / frame_err.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_ctrl_if.slave bus
);

  logic [2:0]                r_state;
  logic [2:0]                w_nxt_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_err_sticky;
  logic                      r_data_valid;
  logic                      r_frame_err;

  logic [PRESCALE_WIDTH-1:0] w_edge_cnt;
  logic [PRESCALE_WIDTH-1:0] w_strb_edge;
  logic [BIT_CNT_WIDTH-1:0]  w_bit_cnt;
  logic                      w_idle;
  logic                      w_start_det;
  logic                      w_eob;
  logic                      w_at_strb;
  logic                      w_last_bit;
  logic                      w_frame_bad;
  logic                      w_frame_end;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_det = w_idle && !bus.RX_IN;
  assign w_strb_edge = PRESCALE_WIDTH'(strobe_edge(8'(r_prescale)));
  assign w_at_strb   = (w_edge_cnt == w_strb_edge);
  assign w_last_bit  = (w_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
  assign w_frame_bad = bus.stp_err | r_err_sticky;
  assign w_frame_end = (r_state == ST_STOP) && w_eob;

  uart_rx_edge_bit_cnt #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
  ) u_cnt (
    .CLK         (CLK),
    .RST         (RST),
    .i_en        (!w_idle),
    .i_clr       (w_idle),
    .i_bit_en    (r_state == ST_DATA),
    .i_prescale  (r_prescale),
    .o_edge_cnt  (w_edge_cnt),
    .o_bit_cnt   (w_bit_cnt),
    .o_end_of_bit(w_eob)
  );

  // Next-state: every transition out of a frame state happens at end of bit.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:   if (!bus.RX_IN) w_nxt_state = ST_START;
      ST_START:  if (w_eob) w_nxt_state = bus.strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_eob && w_last_bit) w_nxt_state = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_eob) w_nxt_state = ST_STOP;
      ST_STOP:   if (w_eob) w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Frame config is captured at start detect so mid-frame input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale <= '0;
      r_par_en   <= 1'b0;
    end else if (w_start_det) begin
      r_prescale <= bus.Prescale;
      r_par_en   <= bus.PAR_EN;
    end
  end

  // Parity error is remembered so the stop bit is still checked before reporting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                              r_err_sticky <= 1'b0;
    else if (w_idle)                                      r_err_sticky <= 1'b0;
    else if ((r_state == ST_PARITY) && w_eob && bus.par_err) r_err_sticky <= 1'b1;
  end

  // End-of-frame result pulses, visible in the first IDLE cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_frame_end && !w_frame_bad;
      r_frame_err  <= w_frame_end &&  w_frame_bad;
    end
  end

  assign bus.edge_cnt    = w_edge_cnt;
  assign bus.bit_cnt     = w_bit_cnt;
  assign bus.dat_samp_en = !w_idle;
  assign bus.busy        = !w_idle;
  assign bus.strt_chk_en = (r_state == ST_START)  && w_at_strb;
  assign bus.deser_en    = (r_state == ST_DATA)   && w_at_strb;
  assign bus.par_chk_en  = (r_state == ST_PARITY) && w_at_strb;
  assign bus.stp_chk_en  = (r_state == ST_STOP)   && w_at_strb;
  assign bus.data_valid  = r_data_valid;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. Cycle 0 of a frame is the first START
// cycle; a monitor logs strobe/pulse cycles relative to that origin and the
// directed steps compare the logs against hand-derived cycle numbers.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_ctrl_if #(.PRESCALE_WIDTH(6), .BIT_CNT_WIDTH(4)) bus ();

  uart_rx_ctrl #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6),
    .BIT_CNT_WIDTH (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int t_org = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_both = 0;
  logic cfg_par_err = 1'b0;
  logic cfg_stp_err = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] r_shift = 8'h00;
  int q_strt[$], q_deser[$], q_bit[$], q_par[$], q_stp[$];
  int q_dv[$], q_fe[$], q_byte[$], q_idle[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Checker models: result registered on the strobe and held until the next one.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.strt_glitch <= 1'b0;
      bus.par_err     <= 1'b0;
      bus.stp_err     <= 1'b0;
    end else begin
      if (bus.strt_chk_en) bus.strt_glitch <= bus.RX_IN;
      if (bus.par_chk_en)  bus.par_err     <= cfg_par_err;
      if (bus.stp_chk_en)  bus.stp_err     <= cfg_stp_err | ~bus.RX_IN;
    end
  end

  // Deserializer model: LSB-first shift on deser_en.
  always @(posedge CLK) if (bus.deser_en) r_shift <= {bus.RX_IN, r_shift[7:1]};

  // Event logger, sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.strt_chk_en) q_strt.push_back(cyc - t_org);
    if (bus.deser_en) begin
      q_deser.push_back(cyc - t_org);
      q_bit.push_back(int'(bus.bit_cnt));
    end
    if (bus.par_chk_en) q_par.push_back(cyc - t_org);
    if (bus.stp_chk_en) q_stp.push_back(cyc - t_org);
    if (bus.data_valid) begin
      q_dv.push_back(cyc - t_org);
      q_byte.push_back(int'(r_shift));
    end
    if (bus.frame_err) q_fe.push_back(cyc - t_org);
    if (bus.data_valid && bus.frame_err) n_both <= n_both + 1;
    if (prev_busy && !bus.busy) q_idle.push_back(cyc - t_org);
    prev_busy <= bus.busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare a logged queue against an arithmetic sequence of n entries.
  task automatic chk_seq(input string tag, input int q[$], input int first,
                         input int step, input int n);
    chk({tag, " count"}, q.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : -1, first + step * i);
  endtask

  task automatic clr_logs();
    q_strt.delete(); q_deser.delete(); q_bit.delete(); q_par.delete();
    q_stp.delete();  q_dv.delete();    q_fe.delete();  q_byte.delete();
    q_idle.delete();
  endtask

  task automatic drive_slot(input logic b, input int p);
    bus.RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // One frame on the line; config inputs are scrambled after the start bit
  // so the latched copies are what governs the rest of the frame.
  task automatic send_frame(input int p, input logic pe, input logic [7:0] d);
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pe;
    drive_slot(1'b0, p);
    bus.Prescale = 6'd5;
    bus.PAR_EN   = ~pe;
    for (int i = 0; i < 8; i++) drive_slot(d[i], p);
    if (pe) drive_slot(^d, p);
    drive_slot(1'b1, p);
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.Prescale = 6'(PRESCALE_8);
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst edge_cnt", int'(bus.edge_cnt), 0);
    chk("rst bit_cnt", int'(bus.bit_cnt), 0);
    chk("rst flags", int'({bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
                           bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.busy}), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // 1: P=8, parity on, 0xA5, clean
    clr_logs();
    cfg_par_err = 1'b0; cfg_stp_err = 1'b0;
    t_org = cyc + 1;
    send_frame(PRESCALE_8, 1'b1, 8'hA5);
    repeat (8) @(negedge CLK);
    chk_seq("t1 strt", q_strt, 6, 8, 1);
    chk_seq("t1 deser", q_deser, 14, 8, 8);
    chk_seq("t1 par", q_par, 78, 8, 1);
    chk_seq("t1 stp", q_stp, 86, 8, 1);
    chk_seq("t1 dv", q_dv, 88, 89, 1);
    chk_seq("t1 fe", q_fe, 0, 0, 0);
    chk_seq("t1 idle", q_idle, 88, 0, 1);
    chk("t1 byte", (q_byte.size() > 0) ? q_byte[0] : -1, 32'hA5);

    // 2: parity error still walks through STOP, reports frame_err
    clr_logs();
    cfg_par_err = 1'b1;
    t_org = cyc + 1;
    send_frame(PRESCALE_8, 1'b1, 8'hA5);
    repeat (8) @(negedge CLK);
    chk_seq("t2 par", q_par, 78, 8, 1);
    chk_seq("t2 stp", q_stp, 86, 8, 1);
    chk_seq("t2 fe", q_fe, 88, 0, 1);
    chk_seq("t2 dv", q_dv, 0, 0, 0);
    cfg_par_err = 1'b0;

    // 3: P=16, no parity, stop error
    clr_logs();
    cfg_stp_err = 1'b1;
    t_org = cyc + 1;
    send_frame(PRESCALE_16, 1'b0, 8'h5A);
    repeat (8) @(negedge CLK);
    chk_seq("t3 strt", q_strt, 10, 16, 1);
    chk_seq("t3 deser", q_deser, 26, 16, 8);
    chk_seq("t3 par", q_par, 0, 0, 0);
    chk_seq("t3 stp", q_stp, 154, 16, 1);
    chk_seq("t3 fe", q_fe, 160, 0, 1);
    chk_seq("t3 dv", q_dv, 0, 0, 0);
    cfg_stp_err = 1'b0;

    // 4: two-cycle start glitch
    clr_logs();
    bus.Prescale = 6'(PRESCALE_8);
    bus.PAR_EN   = 1'b1;
    t_org = cyc + 1;
    bus.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    chk_seq("t4 strt", q_strt, 6, 8, 1);
    chk_seq("t4 idle", q_idle, 8, 0, 1);
    chk_seq("t4 deser", q_deser, 0, 0, 0);
    chk_seq("t4 dv", q_dv, 0, 0, 0);
    chk_seq("t4 fe", q_fe, 0, 0, 0);

    // 5: back-to-back frames 0x3C / 0xC3
    clr_logs();
    t_org = cyc + 1;
    send_frame(PRESCALE_8, 1'b1, 8'h3C);
    @(negedge CLK);
    send_frame(PRESCALE_8, 1'b1, 8'hC3);
    repeat (8) @(negedge CLK);
    chk_seq("t5 dv", q_dv, 88, 89, 2);
    chk_seq("t5 fe", q_fe, 0, 0, 0);
    chk("t5 byte0", (q_byte.size() > 0) ? q_byte[0] : -1, 32'h3C);
    chk("t5 byte1", (q_byte.size() > 1) ? q_byte[1] : -1, 32'hC3);
    chk("t5 bit count", q_bit.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t5 bit_cnt[%0d]", i), (i < q_bit.size()) ? q_bit[i] : -1, i % 8);
    chk("t5 deser f2 first", (q_deser.size() > 8) ? q_deser[8] : -1, 103);

    // 6: async reset in DATA bit 4, then a clean frame
    clr_logs();
    bus.Prescale = 6'(PRESCALE_8);
    bus.PAR_EN   = 1'b0;
    t_org = cyc + 1;
    drive_slot(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_slot(1'b1, 8);
    bus.RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t6 pre bit_cnt", int'(bus.bit_cnt), 4);
    chk("t6 pre busy", int'(bus.busy), 1);
    #2 RST = 1'b1;
    #1;
    chk("t6 rst edge_cnt", int'(bus.edge_cnt), 0);
    chk("t6 rst bit_cnt", int'(bus.bit_cnt), 0);
    chk("t6 rst flags", int'({bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
                              bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.busy}), 0);
    bus.RX_IN = 1'b1;
    @(negedge CLK);
    clr_logs();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t6 no dv", q_dv.size(), 0);
    chk("t6 no fe", q_fe.size(), 0);
    chk("t6 no deser", q_deser.size(), 0);
    t_org = cyc + 1;
    send_frame(PRESCALE_8, 1'b0, 8'h96);
    repeat (8) @(negedge CLK);
    chk_seq("t6 dv", q_dv, 80, 0, 1);
    chk_seq("t6 fe", q_fe, 0, 0, 0);
    chk("t6 byte", (q_byte.size() > 0) ? q_byte[0] : -1, 32'h96);

    chk("dv and fe together", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
